// File: rtl/xfer_ctl.sv
// xfer_ctl: transfer command/length controller feeding a DMA sequencer.
// Ports: PHI2/nRESET clock+reset; CmdWE/CmdD command reg; FF00WE trigger;
//   LenWE/LenD length bytes; StatRE flag clear; DMA/Step/VerifyErr from
//   sequencer; Execute/XferType/Length/Length1/Armed/Busy/EndOfBlock/
//   Fault/Reload status and control outputs.
module xfer_ctl (
    input  logic        PHI2,
    input  logic        nRESET,
    input  logic        CmdWE,
    input  logic [7:0]  CmdD,
    input  logic        FF00WE,
    input  logic [1:0]  LenWE,
    input  logic [7:0]  LenD,
    input  logic        StatRE,
    input  logic        DMA,
    input  logic        Step,
    input  logic        VerifyErr,
    output logic        Execute,
    output logic [1:0]  XferType,
    output logic [15:0] Length,
    output logic        Length1,
    output logic        Armed,
    output logic        Busy,
    output logic        EndOfBlock,
    output logic        Fault,
    output logic        Reload
);

    typedef enum logic [2:0] {
        IDLE, ARMED, START, RUN, FINISH
    } xferState_e;

    xferState_e state;
    xferState_e nxt;
    logic       latchCmd;
    logic       autoLoad;
    logic       ff00Dis;
    logic [15:0] shadow;
    logic       runEnd;
    logic       runErr;
    logic       lenOpen;
    logic       unusedCmd;

    assign unusedCmd = ^{CmdD[6], CmdD[3:2]};
    assign Length1 = (Length == 16'h0001);
    assign runEnd  = (state == RUN) && Step && Length1;
    assign runErr  = (state == RUN) && VerifyErr;
    assign lenOpen = (state == IDLE) || (state == ARMED);

    always_comb begin
        nxt      = state;
        latchCmd = 1'b0;
        unique case (state)
            IDLE, ARMED: begin
                if (CmdWE) begin
                    latchCmd = 1'b1;
                    if (CmdD[7])
                        nxt = CmdD[4] ? START : ARMED;
                    else
                        nxt = IDLE;
                end else if (state == ARMED && FF00WE && !ff00Dis) begin
                    nxt = START;
                end
            end
            START:  if (DMA) nxt = RUN;
            RUN:    if (runEnd || runErr) nxt = FINISH;
            FINISH: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state      <= IDLE;
            Execute    <= 1'b0;
            Reload     <= 1'b0;
            Armed      <= 1'b0;
            Busy       <= 1'b0;
            EndOfBlock <= 1'b0;
            Fault      <= 1'b0;
            XferType   <= 2'b00;
            autoLoad   <= 1'b0;
            ff00Dis    <= 1'b0;
            Length     <= 16'hFFFF;
            shadow     <= 16'hFFFF;
        end else begin
            state   <= nxt;
            Armed   <= (nxt == ARMED);
            Busy    <= (nxt == START) || (nxt == RUN) || (nxt == FINISH);
            Execute <= (nxt == START);
            // autoLoad cannot change while busy, so current value is valid
            Reload  <= (nxt == FINISH) && autoLoad;

            if (latchCmd) begin
                XferType <= CmdD[1:0];
                autoLoad <= CmdD[5];
                ff00Dis  <= CmdD[4];
            end

            if (lenOpen) begin
                if (LenWE[0]) begin
                    Length[7:0] <= LenD;
                    shadow[7:0] <= LenD;
                end
                if (LenWE[1]) begin
                    Length[15:8] <= LenD;
                    shadow[15:8] <= LenD;
                end
            end else if ((runEnd || runErr) && autoLoad) begin
                Length <= shadow;
            end else if ((state == RUN) && Step && !Length1) begin
                Length <= Length - 16'd1;
            end

            // a new set on the same edge as a status read wins
            EndOfBlock <= runEnd || (EndOfBlock && !StatRE);
            Fault      <= runErr || (Fault && !StatRE);
        end
    end

endmodule

// File: tb/tb_xfer_ctl.sv
// tb_xfer_ctl: directed + randomized bench for xfer_ctl against a
// transaction-level model of the command/length/flag behaviour.
module tb_xfer_ctl;

    logic        PHI2 = 1'b0;
    logic        nRESET = 1'b0;
    logic        CmdWE = 1'b0;
    logic [7:0]  CmdD = 8'h00;
    logic        FF00WE = 1'b0;
    logic [1:0]  LenWE = 2'b00;
    logic [7:0]  LenD = 8'h00;
    logic        StatRE = 1'b0;
    logic        DMA = 1'b0;
    logic        Step = 1'b0;
    logic        VerifyErr = 1'b0;
    logic        Execute;
    logic [1:0]  XferType;
    logic [15:0] Length;
    logic        Length1;
    logic        Armed;
    logic        Busy;
    logic        EndOfBlock;
    logic        Fault;
    logic        Reload;

    xfer_ctl dut (
        .PHI2(PHI2), .nRESET(nRESET), .CmdWE(CmdWE), .CmdD(CmdD),
        .FF00WE(FF00WE), .LenWE(LenWE), .LenD(LenD), .StatRE(StatRE),
        .DMA(DMA), .Step(Step), .VerifyErr(VerifyErr),
        .Execute(Execute), .XferType(XferType), .Length(Length),
        .Length1(Length1), .Armed(Armed), .Busy(Busy),
        .EndOfBlock(EndOfBlock), .Fault(Fault), .Reload(Reload)
    );

    always #5 PHI2 = ~PHI2;

    int total = 0;
    int bad = 0;

    // model: phase booleans, remaining count 1..65536, shadow value
    bit         mArmed, mStart, mRun, mFin, mAuto, mEob, mFault;
    logic [1:0] mType;
    int         mRem;
    logic [15:0] mShadow;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int toRem(input logic [15:0] v);
        return (v == 16'h0000) ? 65536 : int'(v);
    endfunction

    task automatic modelReset();
        mArmed = 0; mStart = 0; mRun = 0; mFin = 0;
        mAuto = 0; mEob = 0; mFault = 0;
        mType = 2'b00;
        mRem = 65535;
        mShadow = 16'hFFFF;
    endtask

    task automatic modelEdge();
        bit idle, endHit, errHit, nA, nS, nR, nF;
        logic [15:0] cur;
        idle   = !(mArmed || mStart || mRun || mFin);
        endHit = mRun && Step && (mRem == 1);
        errHit = mRun && VerifyErr;
        nA = mArmed; nS = mStart; nR = mRun; nF = 0;
        if ((idle || mArmed) && CmdWE) begin
            mType = CmdD[1:0];
            mAuto = CmdD[5];
            nA = CmdD[7] && !CmdD[4];
            nS = CmdD[7] && CmdD[4];
        end else if (mArmed && FF00WE) begin
            nA = 0; nS = 1;
        end
        if (mStart && DMA) begin nS = 0; nR = 1; end
        if (endHit || errHit) begin nR = 0; nF = 1; end
        if (idle || mArmed) begin
            cur = mRem[15:0];
            if (LenWE[0]) begin cur[7:0] = LenD; mShadow[7:0] = LenD; end
            if (LenWE[1]) begin cur[15:8] = LenD; mShadow[15:8] = LenD; end
            mRem = toRem(cur);
        end else if (nF && mAuto) begin
            mRem = toRem(mShadow);
        end else if (mRun && Step && mRem != 1) begin
            mRem = mRem - 1;
        end
        mEob   = endHit || (mEob && !StatRE);
        mFault = errHit || (mFault && !StatRE);
        mArmed = nA; mStart = nS; mRun = nR; mFin = nF;
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".exec"}, 32'(Execute), 32'(mStart));
        check({tag, ".armed"}, 32'(Armed), 32'(mArmed));
        check({tag, ".busy"}, 32'(Busy), 32'(mStart || mRun || mFin));
        check({tag, ".len"}, 32'(Length), 32'(mRem[15:0]));
        check({tag, ".len1"}, 32'(Length1), 32'(mRem == 1));
        check({tag, ".eob"}, 32'(EndOfBlock), 32'(mEob));
        check({tag, ".fault"}, 32'(Fault), 32'(mFault));
        check({tag, ".reload"}, 32'(Reload), 32'(mFin && mAuto));
        check({tag, ".type"}, 32'(XferType), 32'(mType));
    endtask

    task automatic clearIn();
        CmdWE = 0; CmdD = 8'h00; FF00WE = 0; LenWE = 2'b00; LenD = 8'h00;
        StatRE = 0; DMA = 0; Step = 0; VerifyErr = 0;
    endtask

    // inputs are set at posedge+1; state moves on the falling edge
    task automatic tick(input string tag);
        @(negedge PHI2);
        modelEdge();
        @(posedge PHI2);
        #1;
        checkAll(tag);
        clearIn();
    endtask

    task automatic setLen(input logic [15:0] v);
        LenWE = 2'b01; LenD = v[7:0]; tick("lenlo");
        LenWE = 2'b10; LenD = v[15:8]; tick("lenhi");
    endtask

    task automatic cmd(input logic [7:0] d);
        CmdWE = 1; CmdD = d; tick("cmd");
    endtask

    task automatic pulseReset(input string tag);
        #2 nRESET = 0;
        #1 modelReset();
        checkAll(tag);
        @(negedge PHI2);
        @(posedge PHI2);
        #1 nRESET = 1;
        checkAll({tag, "_rel"});
    endtask

    initial begin
        modelReset();
        clearIn();
        repeat (2) @(posedge PHI2);
        #1 checkAll("reset");
        nRESET = 1;

        // basic run to end of block
        setLen(16'h0003);
        cmd(8'h90);
        check("r35_exec", 32'(Execute), 32'd1);
        tick("r35_wait");
        DMA = 1; tick("r35_dma");
        check("r35_exec0", 32'(Execute), 32'd0);
        Step = 1; tick("r35_s1");
        check("r35_len2", 32'(Length), 32'h2);
        Step = 1; tick("r35_s2");
        Step = 1; tick("r35_s3");
        check("r35_eob", 32'(EndOfBlock), 32'd1);
        check("r35_len1", 32'(Length), 32'h1);
        check("r35_rld", 32'(Reload), 32'd0);
        tick("r35_fin");

        // armed path, trigger and cancel
        cmd(8'h80);
        check("r36_armed", 32'(Armed), 32'd1);
        check("r36_noexec", 32'(Execute), 32'd0);
        FF00WE = 1; tick("r36_trig");
        check("r36_exec", 32'(Execute), 32'd1);
        DMA = 1; tick("r36_dma");
        VerifyErr = 1; tick("r36_err");
        tick("r36_fin");
        StatRE = 1; tick("r36_clr");
        cmd(8'h80);
        CmdWE = 1; CmdD = 8'h00; FF00WE = 1; tick("r36_cancel");
        check("r36_idle", 32'(Armed), 32'd0);
        FF00WE = 1; tick("r36_ign");
        check("r36_nobusy", 32'(Busy), 32'd0);

        // autoload
        setLen(16'h0002);
        cmd(8'hB3);
        DMA = 1; tick("r37_dma");
        Step = 1; tick("r37_s1");
        Step = 1; tick("r37_s2");
        check("r37_rld", 32'(Reload), 32'd1);
        check("r37_len", 32'(Length), 32'h2);
        check("r37_type", 32'(XferType), 32'd3);
        tick("r37_fin");
        StatRE = 1; tick("r37_clr");

        // verify error, then set-beats-clear
        setLen(16'h0010);
        cmd(8'h93);
        DMA = 1; tick("r38_dma");
        repeat (4) begin Step = 1; tick("r38_step"); end
        VerifyErr = 1; tick("r38_err");
        check("r38_fault", 32'(Fault), 32'd1);
        check("r38_eob", 32'(EndOfBlock), 32'd0);
        check("r38_len", 32'(Length), 32'h000C);
        tick("r38_fin");
        cmd(8'h90);
        DMA = 1; tick("r38_dma2");
        VerifyErr = 1; StatRE = 1; tick("r38_both");
        check("r38_keep", 32'(Fault), 32'd1);
        tick("r38_fin2");
        StatRE = 1; tick("r38_clr");
        check("r38_clr0", 32'(Fault), 32'd0);

        // wrap from 0, then async reset in START and in RUN
        setLen(16'h0000);
        cmd(8'h90);
        DMA = 1; tick("r39_dma");
        Step = 1; tick("r39_step");
        check("r39_wrap", 32'(Length), 32'hFFFF);
        pulseReset("r39_rstrun");
        cmd(8'h90);
        check("r39_exec1", 32'(Execute), 32'd1);
        pulseReset("r39_rststart");
        check("r39_exec0", 32'(Execute), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            CmdWE = ($urandom % 8) == 0;
            CmdD = 8'($urandom);
            FF00WE = ($urandom % 4) == 0;
            LenWE = (($urandom % 6) == 0) ? 2'($urandom) : 2'b00;
            LenD = ($urandom % 2) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            StatRE = ($urandom % 8) == 0;
            DMA = ($urandom % 3) == 0;
            Step = ($urandom % 2) == 0;
            VerifyErr = ($urandom % 24) == 0;
            if (($urandom % 400) == 0) begin
                clearIn();
                pulseReset("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xfer_ctl.md
XFER_CTL -- requirements
Module: xfer_ctl

Interface
REQ-001 SHALL provide: PHI2  in  1  sole clock; all state updates on falling edge of PHI2.
REQ-002 SHALL provide: nRESET  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: CmdWE  in  1  CPU write strobe to command register.
REQ-004 SHALL provide: CmdD  in  8  command data; bit7 execute, bit5 autoload, bit4 FF00-trigger disable, bits1:0 transfer type.
REQ-005 SHALL provide: FF00WE  in  1  CPU write to $FF00 detected.
REQ-006 SHALL provide: LenWE  in  2  length byte write enables; [1] high byte, [0] low byte.
REQ-007 SHALL provide: LenD  in  8  length write data.
REQ-008 SHALL provide: StatRE  in  1  status read strobe; clears sticky flags.
REQ-009 SHALL provide: DMA  in  1  DMA-active feedback from sequencer.
REQ-010 SHALL provide: Step  in  1  sequencer completed one transfer unit.
REQ-011 SHALL provide: VerifyErr  in  1  sequencer verify mismatch.
REQ-012 SHALL provide: Execute  out  1  start request to sequencer.
REQ-013 SHALL provide: XferType  out  2  latched transfer type.
REQ-014 SHALL provide: Length  out  16  current remaining count; 0 encodes 65536.
REQ-015 SHALL provide: Length1  out  1  high when Length==16'h0001.
REQ-016 SHALL provide: Armed, Busy  out  1 each  state indicators.
REQ-017 SHALL provide: EndOfBlock, Fault  out  1 each  sticky status flags.
REQ-018 SHALL provide: Reload  out  1  one-cycle autoload pulse to address registers.

Function
REQ-019 SHALL implement states IDLE, ARMED, START, RUN, FINISH; Armed=(ARMED); Busy=(START|RUN|FINISH).
REQ-020 IDLE: CmdWE with CmdD[7]=1 SHALL latch XferType, autoload, FF00-disable; next state START if CmdD[4]=1, else ARMED; CmdD[7]=0 SHALL latch fields and stay IDLE.
REQ-021 ARMED: FF00WE SHALL go to START; CmdWE with CmdD[7]=0 SHALL go to IDLE; CmdWE with CmdD[7]=1 SHALL relatch fields and reapply REQ-020 routing; CmdWE and FF00WE together: CmdWE wins.
REQ-022 START: Execute SHALL be 1; hold until DMA=1 sampled, then RUN (Execute 0 from that edge).
REQ-023 RUN: Step with Length1 OR VerifyErr SHALL go to FINISH; Execute SHALL be 0.
REQ-024 FINISH: one cycle, then IDLE; Reload=1 in FINISH iff autoload latched.
REQ-025 CmdWE SHALL be ignored in START, RUN, FINISH; FF00WE ignored outside ARMED.
REQ-026 Step in RUN with Length!=1 SHALL decrement Length by 1, 16-bit wrap (0 -> FFFF).
REQ-027 Step with Length1: Length SHALL stay 1 unless autoload, in which case Length SHALL load shadow value at FINISH.
REQ-028 VerifyErr terminating early with autoload SHALL also reload Length from shadow at FINISH.
REQ-029 LenWE in IDLE/ARMED SHALL write addressed byte into both Length and shadow; ignored in START/RUN/FINISH.
REQ-030 EndOfBlock SHALL set on entry to FINISH caused by Step with Length1; Fault SHALL set on entry caused by VerifyErr; both set if simultaneous.
REQ-031 StatRE SHALL clear EndOfBlock and Fault; set on same edge SHALL win over clear.
REQ-032 Step outside RUN SHALL be ignored.

Reset
REQ-033 nRESET low SHALL immediately force IDLE, Execute=0, Reload=0, Armed=0, Busy=0, EndOfBlock=0, Fault=0, XferType=00, autoload=0, FF00-disable=0, Length=shadow=16'hFFFF, Length1=0.
REQ-034 Reset asserted mid-RUN SHALL abort with no FINISH, no Reload, no flag set.

Verification
REQ-035 Length=0003, Cmd=0x90 -> START next edge, Execute high until DMA=1; three Steps -> Length 2,1 then FINISH, EndOfBlock=1, Length stays 1, Reload=0.
REQ-036 Cmd=0x80 -> ARMED, no Execute; FF00WE -> START; repeat with CmdWE 0x00 while ARMED -> IDLE, FF00WE ignored.
REQ-037 Shadow=0002, Cmd=0xB3, two Steps -> FINISH with Reload=1, Length reloads 0002.
REQ-038 Cmd=0x93, Length=0010, VerifyErr after 4 Steps -> Fault=1, EndOfBlock=0, Length=000C; StatRE same edge as a new set keeps flag 1.
REQ-039 Length=0000, one Step -> FFFF; nRESET pulse mid-RUN -> IDLE, Execute 0 asynchronously, Length FFFF, no flags.
